// File: rtl/pc_unit.sv
// Program counter with a hardware return-address stack.
// Owns the 16-bit fetch address, takes resolved jump targets from the jump
// unit, and pushes/pops return addresses for call/ret.
// Priority per cycle: ret > load > inc > hold.
module pc_unit #(
   parameter int unsigned DEPTH    = 8,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inc,
   input  logic                     load,
   input  logic [15:0]              load_addr,
   input  logic                     call,
   input  logic                     ret,
   input  logic                     fault_clr,
   output logic [15:0]              pc,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     stack_empty,
   output logic                     stack_full,
   output logic                     fault
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned DW = AW + 1;
   localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

   logic [15:0]   pc_q, pc_d;
   logic [DW-1:0] depth_q, depth_d;
   logic          fault_q, fault_d;
   logic [15:0]   stack_q [DEPTH];

   logic          push_en;
   logic [AW-1:0] push_idx;
   logic [AW-1:0] pop_idx;
   logic          set_fault;
   logic          is_empty;
   logic          is_full;

   assign is_empty = (depth_q == '0);
   assign is_full  = (depth_q == FULL_CNT);

   // Next-state selection: pc, depth, fault and the stack write request.
   always_comb begin
      pc_d      = pc_q;
      depth_d   = depth_q;
      push_en   = 1'b0;
      set_fault = 1'b0;
      push_idx  = AW'(depth_q);
      pop_idx   = AW'(depth_q - DW'(1));

      if (ret) begin
         if (!is_empty) begin
            pc_d    = stack_q[pop_idx];
            depth_d = depth_q - DW'(1);
         end else begin
            set_fault = 1'b1;
         end
      end else if (load) begin
         pc_d = load_addr;
         if (call) begin
            if (is_full) begin
               set_fault = 1'b1;
            end else begin
               push_en = 1'b1;
               depth_d = depth_q + DW'(1);
            end
         end
      end else if (inc) begin
         pc_d = pc_q + 16'd1;
      end

      if (set_fault) begin
         fault_d = 1'b1;
      end else if (fault_clr) begin
         fault_d = 1'b0;
      end else begin
         fault_d = fault_q;
      end
   end

   // Architectural registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         depth_q <= '0;
         fault_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         depth_q <= depth_d;
         fault_q <= fault_d;
      end
   end

   // Stack RAM: not reset; the push stores the pre-jump pc.
   always_ff @(posedge clk) begin
      if (push_en && !rst) begin
         stack_q[push_idx] <= pc_q;
      end
   end

   assign pc          = pc_q;
   assign depth       = depth_q;
   assign stack_empty = is_empty;
   assign stack_full  = is_full;
   assign fault       = fault_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: queue-based reference model checked every
// cycle, plus directed vectors with literal expected values.
module tb_pc_unit;

   localparam int unsigned DEPTH = 8;
   localparam logic [15:0] RST_PC = 16'h0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inc = 1'b0;
   logic        load = 1'b0;
   logic [15:0] load_addr = 16'h0000;
   logic        call = 1'b0;
   logic        ret = 1'b0;
   logic        fault_clr = 1'b0;
   logic [15:0] pc;
   logic [3:0]  depth;
   logic        stack_empty;
   logic        stack_full;
   logic        fault;

   int n_checks = 0;
   int n_fail   = 0;

   pc_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .inc(inc), .load(load), .load_addr(load_addr),
      .call(call), .ret(ret), .fault_clr(fault_clr), .pc(pc), .depth(depth),
      .stack_empty(stack_empty), .stack_full(stack_full), .fault(fault)
   );

   always #5 clk = ~clk;

   // Reference model: return stack as a queue, pc as a plain 16-bit number.
   logic [15:0] m_pc = RST_PC;
   logic [15:0] m_stk [$];
   logic        m_fault = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc = RST_PC;
         m_stk.delete();
         m_fault = 1'b0;
      end else begin
         logic err;
         err = 1'b0;
         if (ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else err = 1'b1;
         end else if (load) begin
            if (call) begin
               if (m_stk.size() < DEPTH) m_stk.push_back(m_pc);
               else err = 1'b1;
            end
            m_pc = load_addr;
         end else if (inc) begin
            m_pc = m_pc + 16'd1;
         end
         if (err) m_fault = 1'b1;
         else if (fault_clr) m_fault = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("model_pc", 32'(pc), 32'(m_pc));
      chk("model_depth", 32'(depth), 32'(m_stk.size()));
      chk("model_empty", 32'(stack_empty), 32'(m_stk.size() == 0));
      chk("model_full", 32'(stack_full), 32'(m_stk.size() == DEPTH));
      chk("model_fault", 32'(fault), 32'(m_fault));
   end

   task automatic step(input logic i_inc, input logic i_load, input logic [15:0] a,
                       input logic i_call, input logic i_ret, input logic i_clr);
      inc = i_inc; load = i_load; load_addr = a; call = i_call; ret = i_ret; fault_clr = i_clr;
      @(posedge clk);
      #1;
      inc = 1'b0; load = 1'b0; load_addr = 16'h0000; call = 1'b0; ret = 1'b0; fault_clr = 1'b0;
   endtask

   initial begin
      logic [15:0] pushed [8];
      #1 rst = 1'b1;
      #11;
      chk("rst_pc", 32'(pc), 32'h0000);
      chk("rst_depth", 32'(depth), 32'd0);
      chk("rst_empty", 32'(stack_empty), 32'd1);
      chk("rst_full", 32'(stack_full), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk) #1;

      // inc from reset and wrap
      step(1, 0, 16'h0000, 0, 0, 0); chk("inc1", 32'(pc), 32'h0001);
      step(1, 0, 16'h0000, 0, 0, 0); chk("inc2", 32'(pc), 32'h0002);
      step(1, 0, 16'h0000, 0, 0, 0); chk("inc3", 32'(pc), 32'h0003);
      step(0, 0, 16'h0000, 0, 0, 0); chk("hold", 32'(pc), 32'h0003);
      step(0, 1, 16'hFFFF, 0, 0, 0); chk("preload", 32'(pc), 32'hFFFF);
      step(1, 0, 16'h0000, 0, 0, 0); chk("wrap", 32'(pc), 32'h0000);
      chk("wrap_fault", 32'(fault), 32'd0);

      // load beats inc
      step(0, 1, 16'h0010, 0, 0, 0);
      step(1, 1, 16'h1234, 0, 0, 0);
      chk("jmp_pc", 32'(pc), 32'h1234);
      chk("jmp_depth", 32'(depth), 32'd0);
      step(0, 0, 16'h5555, 1, 0, 0); chk("call_no_load", 32'(depth), 32'd0);

      // nested call/ret
      step(0, 1, 16'h0100, 0, 0, 0);
      step(0, 1, 16'h2000, 1, 0, 0);
      chk("call1_pc", 32'(pc), 32'h2000);
      chk("call1_depth", 32'(depth), 32'd1);
      for (int i = 0; i < 5; i++) step(1, 0, 16'h0000, 0, 0, 0);
      chk("at2005", 32'(pc), 32'h2005);
      step(0, 1, 16'h3000, 1, 0, 0);
      chk("call2_depth", 32'(depth), 32'd2);
      step(0, 0, 16'h0000, 0, 1, 0);
      chk("ret1_pc", 32'(pc), 32'h2005);
      chk("ret1_depth", 32'(depth), 32'd1);
      step(0, 0, 16'h0000, 0, 1, 0);
      chk("ret2_pc", 32'(pc), 32'h0100);
      chk("ret2_empty", 32'(stack_empty), 32'd1);

      // overflow: 8 calls fill the stack, 9th still jumps
      for (int i = 0; i < 8; i++) begin
         pushed[i] = (i == 0) ? 16'h0100 : 16'(16'h1000 + (i - 1) * 16'h0100);
         step(0, 1, 16'(16'h1000 + i * 16'h0100), 1, 0, 0);
      end
      chk("full_flag", 32'(stack_full), 32'd1);
      chk("full_fault0", 32'(fault), 32'd0);
      step(0, 1, 16'hABCD, 1, 0, 0);
      chk("ovf_pc", 32'(pc), 32'hABCD);
      chk("ovf_depth", 32'(depth), 32'd8);
      chk("ovf_fault", 32'(fault), 32'd1);
      for (int j = 0; j < 8; j++) begin
         step(0, 0, 16'h0000, 0, 1, 0);
         chk("lifo_pop", 32'(pc), 32'(pushed[7 - j]));
      end
      chk("lifo_last", 32'(pc), 32'h0100);
      chk("lifo_empty", 32'(stack_empty), 32'd1);
      step(0, 0, 16'h0000, 0, 0, 1); chk("clr", 32'(fault), 32'd0);

      // underflow and clear
      step(0, 1, 16'h0042, 0, 0, 0);
      step(1, 1, 16'h7777, 1, 1, 0);
      chk("unf_pc", 32'(pc), 32'h0042);
      chk("unf_depth", 32'(depth), 32'd0);
      chk("unf_fault", 32'(fault), 32'd1);
      step(0, 0, 16'h0000, 0, 0, 0); chk("fault_sticky", 32'(fault), 32'd1);
      step(0, 0, 16'h0000, 0, 0, 1); chk("unf_clr", 32'(fault), 32'd0);
      step(0, 0, 16'h0000, 0, 1, 1); chk("set_wins", 32'(fault), 32'd1);
      step(0, 0, 16'h0000, 0, 0, 1);

      // ret beats load+call
      step(0, 1, 16'h0555, 0, 0, 0);
      step(0, 1, 16'h0777, 1, 0, 0);
      step(0, 1, 16'h9999, 1, 1, 0);
      chk("rlc_pc", 32'(pc), 32'h0555);
      chk("rlc_depth", 32'(depth), 32'd0);
      // back-to-back call then ret
      step(0, 1, 16'h0900, 1, 0, 0);
      step(0, 0, 16'h0000, 0, 1, 0);
      chk("b2b_pc", 32'(pc), 32'h0555);
      step(1, 1, 16'h0A00, 1, 0, 0);
      step(0, 1, 16'h0B00, 1, 0, 0);
      chk("pre_rst_depth", 32'(depth), 32'd2);

      // async reset mid-operation
      inc = 1'b1; load = 1'b1; load_addr = 16'h0C00; call = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("arst_pc", 32'(pc), 32'(RST_PC));
      chk("arst_depth", 32'(depth), 32'd0);
      chk("arst_empty", 32'(stack_empty), 32'd1);
      inc = 1'b0; load = 1'b0; load_addr = 16'h0000; call = 1'b0;
      @(negedge clk) rst = 1'b0;
      @(posedge clk) #1;
      step(0, 0, 16'h0000, 0, 1, 0);
      chk("post_rst_unf", 32'(fault), 32'd1);
      step(1, 0, 16'h0000, 0, 0, 1);
      chk("post_rst_inc", 32'(pc), 32'h0001);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program counter with a hardware return-address stack for the 8-bit CPU. It owns the 16-bit fetch address and supplies it as the base for PC-relative jumps. It consumes the jump unit's resolved target and taken strobe, and adds call/return support by pushing and popping return addresses. Sits between the jump unit and the fetch/sequencer logic.

## Interface
Parameters:
- DEPTH, 8, number of return-stack entries; power of two, 2..64
- RESET_PC, 16'h0000, PC value after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- inc  in  1  advance PC by one (fetch of an instruction or operand byte)
- load  in  1  jump taken; connect to the jump unit's taken strobe
- load_addr  in  16  jump target; connect to the jump unit's target bus (already resolved absolute/relative)
- call  in  1  qualifies load as a call: push return address
- ret  in  1  pop return stack into PC
- fault_clr  in  1  clear sticky fault
- pc  out  16  current PC; also feeds the jump unit's relative-jump base
- depth  out  $clog2(DEPTH)+1  number of valid stack entries
- stack_empty  out  1  depth == 0
- stack_full  out  1  depth == DEPTH
- fault  out  1  sticky; stack overflow or underflow occurred

## Operation
- State: pc register, DEPTH x 16 stack RAM, depth counter, fault flag.
- Per-cycle action priority: ret > load > inc > hold.
- ret, depth > 0: pc <= stack[depth-1]; depth decrements. load, call and inc are ignored that cycle.
- ret, depth == 0 (underflow): pc held; depth stays 0; fault set.
- load, call=0: pc <= load_addr; stack untouched.
- load, call=1, not full: stack[depth] <= pc (pre-load value; the sequencer has already advanced past the operand bytes); depth increments; pc <= load_addr.
- load, call=1, full (overflow): the jump is still taken (pc <= load_addr). The push is discarded; depth stays DEPTH; fault set.
- call without load: ignored, no push.
- inc only: pc <= pc + 1, modulo 2^16 (16'hFFFF -> 16'h0000, no flag).
- fault: set on overflow/underflow. Cleared by fault_clr; if set and clear occur in the same cycle, set wins. Held otherwise.
- stack_empty, stack_full and depth are derived combinationally from the depth register.
- Stack contents are not reset. Only entries below depth are meaningful.

## Timing
- Reset (async assert): pc = RESET_PC, depth = 0, stack_empty = 1, stack_full = 0, fault = 0. Release is synchronous to the next clk edge.
- Reset mid-operation discards all stack entries and any in-flight action.
- All actions take effect at the rising edge where they are sampled. pc, depth and fault show the new value one cycle after the strobe.
- Call followed by ret on the next cycle returns the address pushed one cycle earlier. The stack write must be visible to the following pop; no extra latency is allowed.
- pc is a registered output, with no combinational path from any input to pc.
- load_addr is sampled only when load = 1.
- Back-to-back strobes every cycle are supported with no bubbles.

## Test plan
- Reset/inc: assert rst, release, 3 cycles inc -> pc 0000, 0001, 0002, 0003; flags empty=1, full=0, fault=0. Preload pc=FFFF then inc -> pc=0000.
- Jump vs inc priority: pc=0010, load=1, load_addr=1234, inc=1 -> pc=1234, depth=0.
- Nested call/ret: pc=0100, call to 2000; at pc=2005 call to 3000; ret -> pc=2005, depth=1; ret -> pc=0100, depth=0, empty=1.
- Overflow: DEPTH=8, perform 8 calls -> full=1. A 9th call to ABCD -> pc=ABCD, depth=8, fault=1. 8 rets then return the first 8 addresses in LIFO order.
- Underflow and clear: empty stack, ret at pc=0042 -> pc=0042, fault=1. Pulse fault_clr -> fault=0. Underflow together with fault_clr in the same cycle -> fault=1.
- Simultaneous ret+load+call with depth=1, top entry=0555 -> pc=0555, depth=0, no push. Then assert async rst mid-sequence -> pc=RESET_PC, depth=0 immediately.
